bcd_updown_counter_n: RTL

- Parametrised N-digit decimal (BCD) up/down event counter with a built-in tick prescaler and per-digit 7-segment drive.
- Successor to the fixed 3-digit ripple-clocked seconds counter.
- Fully synchronous: one clock, digit carries as enables, no derived clocks.
- Adds direction control, parallel load, wrap/borrow reporting, sticky overflow and optional leading-zero blanking; sits between the board clock and the HEX displays.

---
 rtl/bcd_updown_counter_n.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down event counter with tick prescaler, parallel load,
// wrap/overflow reporting and active-low 7-segment drive per digit.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50000000,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  clr_ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  wrap,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]       ps_cnt;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_step;
  logic [4*DIGITS-1:0] bcd_load;
  logic                all_edge;
  logic                load_bad;
  logic                step_run;
  logic [3:0]          step_d;
  logic [3:0]          ld_nib;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // A digit steps only while every lower digit sits at its rollover value.
  always_comb begin
    bcd_step = bcd_q;
    step_run = 1'b1;
    step_d   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      step_d = bcd_q[4*i +: 4];
      if (up_dn) begin
        if (step_run) bcd_step[4*i +: 4] = (step_d == 4'd9) ? 4'd0 : step_d + 4'd1;
        step_run = step_run && (step_d == 4'd9);
      end else begin
        if (step_run) bcd_step[4*i +: 4] = (step_d == 4'd0) ? 4'd9 : step_d - 4'd1;
        step_run = step_run && (step_d == 4'd0);
      end
    end
    all_edge = step_run;
  end

  always_comb begin
    bcd_load = '0;
    load_bad = 1'b0;
    ld_nib   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      ld_nib = load_val[4*i +: 4];
      if (ld_nib > 4'd9) load_bad = 1'b1;
      else               bcd_load[4*i +: 4] = ld_nib;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ps_cnt   <= '0;
      bcd_q    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        ps_cnt   <= '0;
        bcd_q    <= bcd_load;
        load_err <= load_bad;
      end else begin
        if (enable) begin
          if (ps_cnt == PS_MAX) begin
            ps_cnt <= '0;
            tick   <= 1'b1;
          end else begin
            ps_cnt <= ps_cnt + PW'(1);
          end
        end
        if (tick) begin
          bcd_q <= bcd_step;
          wrap  <= all_edge;
        end
      end
      // The registered wrap pulse sets the flag, so a clear in that cycle loses.
      if (wrap)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign bcd = bcd_q;

  logic       zero_above;
  logic [6:0] seg_pat;

  always_comb begin
    seg        = '1;
    zero_above = 1'b1;
    seg_pat    = 7'b1111111;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      seg_pat    = seg7(bcd_q[4*i +: 4]);
      if ((BLANK_LZ != 0) && (i > 0) && zero_above) seg_pat = 7'b1111111;
      seg[7*i +: 7] = seg_pat;
    end
  end

endmodule
